// File: rtl/stack_alu_sequencer.sv
// Sequences an external 8-deep stack through push, pop and two-operand ALU commands.
// Tracks stack occupancy internally and cross-checks it against the stack's own flags.
module stack_alu_sequencer (
   input  logic       clk,
   input  logic       reset_not,
   input  logic       cmd_valid,
   input  logic [2:0] opcode,
   input  logic [7:0] operand,
   output logic       Push,
   output logic       Pop,
   output logic [7:0] din,
   input  logic [7:0] dout,
   input  logic       full,
   input  logic       empty,
   output logic       busy,
   output logic [7:0] result,
   output logic       result_valid,
   output logic [1:0] error,
   output logic [3:0] depth
);

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned DEPTH_W = 4;
   localparam int unsigned STACK_N = 8;

   localparam logic [2:0] OP_PUSH = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_POP  = 3'b110;
   localparam logic [2:0] OP_NOP  = 3'b111;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_UNF  = 2'b01;
   localparam logic [1:0] ERR_OVF  = 2'b10;
   localparam logic [1:0] ERR_FLAG = 2'b11;

   typedef enum logic [2:0] {
      IDLE, POP_B, CAP_B, POP_A, CAP_A, PUSH_R, DONE
   } state_t;

   state_t              state;
   logic [2:0]          op_q;
   logic [DATA_W-1:0]   operand_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;

   // a is the deeper operand, b the old top of stack
   function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
      case (op)
         OP_ADD:  alu = DATA_W'(a + b);
         OP_SUB:  alu = DATA_W'(a - b);
         OP_AND:  alu = a & b;
         OP_OR:   alu = a | b;
         OP_XOR:  alu = a ^ b;
         default: alu = a;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset_not) begin
      if (!reset_not) begin
         state        <= IDLE;
         op_q         <= OP_PUSH;
         operand_q    <= '0;
         a_q          <= '0;
         b_q          <= '0;
         Push         <= 1'b0;
         Pop          <= 1'b0;
         din          <= '0;
         busy         <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         error        <= ERR_OK;
         depth        <= '0;
      end else begin
         Push         <= 1'b0;
         Pop          <= 1'b0;
         result_valid <= 1'b0;
         // occupancy follows the strobe issued in the previous cycle
         if (Push)
            depth <= depth + DEPTH_W'(1);
         else if (Pop)
            depth <= depth - DEPTH_W'(1);

         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op_q      <= opcode;
                  operand_q <= operand;
                  busy      <= 1'b1;
                  error     <= ERR_OK;
                  case (opcode)
                     OP_PUSH: begin
                        if (depth == DEPTH_W'(STACK_N)) begin
                           error        <= ERR_OVF;
                           state        <= DONE;
                           result_valid <= 1'b1;
                        end else begin
                           din   <= operand;
                           Push  <= 1'b1;
                           state <= PUSH_R;
                        end
                     end
                     OP_POP: begin
                        if (depth == '0) begin
                           error        <= ERR_UNF;
                           state        <= DONE;
                           result_valid <= 1'b1;
                        end else begin
                           Pop   <= 1'b1;
                           state <= POP_B;
                        end
                     end
                     OP_NOP: begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                     end
                     default: begin
                        if (depth < DEPTH_W'(2)) begin
                           error        <= ERR_UNF;
                           state        <= DONE;
                           result_valid <= 1'b1;
                        end else begin
                           Pop   <= 1'b1;
                           state <= POP_B;
                        end
                     end
                  endcase
               end
            end
            POP_B: state <= CAP_B;
            CAP_B: begin
               b_q <= dout;
               if (op_q == OP_POP) begin
                  result       <= dout;
                  state        <= DONE;
                  result_valid <= 1'b1;
               end else begin
                  Pop   <= 1'b1;
                  state <= POP_A;
               end
            end
            POP_A: state <= CAP_A;
            CAP_A: begin
               a_q   <= dout;
               din   <= alu(op_q, dout, b_q);
               Push  <= 1'b1;
               state <= PUSH_R;
            end
            PUSH_R: begin
               result       <= (op_q == OP_PUSH) ? operand_q : alu(op_q, a_q, b_q);
               state        <= DONE;
               result_valid <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (error == ERR_OK &&
                   (((depth == '0) != empty) || ((depth == DEPTH_W'(STACK_N)) != full)))
                  error <= ERR_FLAG;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: acts as the external stack and checks every command
// against a queue-based model of stack semantics.
module tb_stack_alu_sequencer;

   logic       clk = 1'b0;
   logic       reset_not;
   logic       cmd_valid;
   logic [2:0] opcode;
   logic [7:0] operand;
   logic       Push, Pop;
   logic [7:0] din;
   logic [7:0] dout;
   logic       full, empty;
   logic       busy;
   logic [7:0] result;
   logic       result_valid;
   logic [1:0] error;
   logic [3:0] depth;

   int checks = 0;
   int errors = 0;

   stack_alu_sequencer dut (
      .clk(clk), .reset_not(reset_not), .cmd_valid(cmd_valid), .opcode(opcode),
      .operand(operand), .Push(Push), .Pop(Pop), .din(din), .dout(dout),
      .full(full), .empty(empty), .busy(busy), .result(result),
      .result_valid(result_valid), .error(error), .depth(depth)
   );

   always #5 clk = ~clk;

   // external stack: pop data appears the cycle after Pop
   logic [7:0] stk[$];
   int         stk_n = 0;
   logic       flip_empty = 1'b0;
   always @(posedge clk or negedge reset_not) begin
      if (!reset_not) begin
         stk.delete();
         stk_n = 0;
         dout <= 8'h00;
      end else begin
         if (Push && stk.size() < 8) stk.push_back(din);
         if (Pop && stk.size() > 0) dout <= stk.pop_back();
         stk_n = stk.size();
      end
   end
   assign empty = (stk_n == 0) ^ flip_empty;
   assign full  = (stk_n == 8);

   // strobe bookkeeping: counts and protocol violations
   int   push_cnt = 0, pop_cnt = 0, strobe_viol = 0;
   logic prev_strobe = 1'b0;
   always @(posedge clk) begin
      if (Push) push_cnt <= push_cnt + 1;
      if (Pop)  pop_cnt  <= pop_cnt + 1;
      if ((Push && Pop) || ((Push || Pop) && prev_strobe)) strobe_viol <= strobe_viol + 1;
      prev_strobe <= Push || Pop;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model: stack semantics in plain queue arithmetic
   logic [7:0] ref_stk[$];
   logic [7:0] ref_result = 8'h00;

   task automatic model(input logic [2:0] op, input logic [7:0] opnd,
                        output logic [1:0] e_err, output int e_lat,
                        output int e_push, output int e_pop);
      logic [7:0] a, b, r;
      e_err = 2'b00; e_lat = 1; e_push = 0; e_pop = 0;
      case (op)
         3'b000: if (ref_stk.size() == 8) e_err = 2'b10;
                 else begin ref_stk.push_back(opnd); ref_result = opnd; e_lat = 2; e_push = 1; end
         3'b110: if (ref_stk.size() == 0) e_err = 2'b01;
                 else begin ref_result = ref_stk.pop_back(); e_lat = 3; e_pop = 1; end
         3'b111: ;
         default: if (ref_stk.size() < 2) e_err = 2'b01;
         else begin
            b = ref_stk.pop_back();
            a = ref_stk.pop_back();
            case (op)
               3'b001:  r = 8'((int'(a) + int'(b)) % 256);
               3'b010:  r = 8'((int'(a) - int'(b) + 256) % 256);
               3'b011:  r = a & b;
               3'b100:  r = a | b;
               default: r = a ^ b;
            endcase
            ref_stk.push_back(r);
            ref_result = r;
            e_lat = 6; e_push = 1; e_pop = 2;
         end
      endcase
   endtask

   // issue one command from an IDLE negedge; returns at the IDLE negedge after DONE
   task automatic run_cmd(input logic [2:0] op, input logic [7:0] opnd, input bit hold);
      logic [1:0] e_err;
      int e_lat, e_push, e_pop, p0, q0, lat;
      model(op, opnd, e_err, e_lat, e_push, e_pop);
      if (flip_empty && e_err == 2'b00) e_err = 2'b11;
      p0 = push_cnt; q0 = pop_cnt;
      cmd_valid = 1'b1; opcode = op; operand = opnd;
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
      lat = 1;
      while (!result_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      cmd_valid = 1'b0;
      chk("latency", 32'(lat), 32'(e_lat));
      chk("result", 32'(result), 32'(ref_result));
      chk("depth", 32'(depth), 32'(ref_stk.size()));
      @(negedge clk);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("error", 32'(error), 32'(e_err));
      chk("push_strobes", 32'(push_cnt - p0), 32'(e_push));
      chk("pop_strobes", 32'(pop_cnt - q0), 32'(e_pop));
   endtask

   task automatic chk_reset_outputs();
      chk("rst_Push", 32'(Push), 32'd0);
      chk("rst_Pop", 32'(Pop), 32'd0);
      chk("rst_din", 32'(din), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_result_valid", 32'(result_valid), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_depth", 32'(depth), 32'd0);
   endtask

   initial begin
      int p0;
      reset_not = 1'b0; cmd_valid = 1'b0; opcode = 3'b111; operand = 8'h00;
      repeat (2) @(negedge clk);
      chk_reset_outputs();
      reset_not = 1'b1;

      // underflow right after reset, then with a single entry
      run_cmd(3'b001, 8'h00, 1'b0);
      run_cmd(3'b000, 8'h07, 1'b0);
      run_cmd(3'b001, 8'h00, 1'b0);
      run_cmd(3'b110, 8'h00, 1'b0);

      // 5 - 3, then pop the difference
      run_cmd(3'b000, 8'h05, 1'b0);
      run_cmd(3'b000, 8'h03, 1'b0);
      run_cmd(3'b010, 8'h00, 1'b0);
      run_cmd(3'b110, 8'h00, 1'b0);

      // wrapping add followed by subtract
      run_cmd(3'b000, 8'hF0, 1'b0);
      run_cmd(3'b000, 8'h20, 1'b0);
      run_cmd(3'b001, 8'h00, 1'b0);
      run_cmd(3'b000, 8'h01, 1'b0);
      run_cmd(3'b010, 8'h00, 1'b0);
      run_cmd(3'b111, 8'h00, 1'b0);
      run_cmd(3'b110, 8'h00, 1'b0);
      run_cmd(3'b110, 8'h00, 1'b0);

      // fill to eight, then overflow
      for (int i = 1; i <= 9; i++) run_cmd(3'b000, 8'(i), 1'b0);
      chk("full_flag", 32'(full), 32'd1);

      // corrupted empty flag is reported after DONE, cleared by the next accept
      for (int i = 0; i < 7; i++) run_cmd(3'b110, 8'h00, 1'b0);
      flip_empty = 1'b1;
      run_cmd(3'b111, 8'h00, 1'b0);
      flip_empty = 1'b0;
      run_cmd(3'b111, 8'h00, 1'b0);

      // cmd_valid held high through a binary op
      run_cmd(3'b000, 8'h3C, 1'b0);
      run_cmd(3'b101, 8'h00, 1'b1);
      run_cmd(3'b110, 8'h00, 1'b0);

      // reset during CAP_A of an XOR
      run_cmd(3'b000, 8'hA5, 1'b0);
      run_cmd(3'b000, 8'h0F, 1'b0);
      cmd_valid = 1'b1; opcode = 3'b101; operand = 8'h00;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      p0 = push_cnt;
      reset_not = 1'b0;
      #1;
      chk_reset_outputs();
      repeat (3) @(negedge clk);
      reset_not = 1'b1;
      repeat (2) @(negedge clk);
      chk("no_push_after_reset", 32'(push_cnt - p0), 32'd0);
      chk("depth_after_reset", 32'(depth), 32'd0);
      ref_stk.delete();
      ref_result = 8'h00;

      // randomized command stream, biased toward pushes
      for (int i = 0; i < 120; i++) begin
         logic [2:0] op;
         op = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
         run_cmd(op, 8'($urandom), 1'($urandom_range(0, 1)));
      end

      chk("strobe_protocol", 32'(strobe_viol), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/stack_alu_sequencer.md
STACK_ALU_SEQUENCER -- requirements
Module: stack_alu_sequencer

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have the port reset_not, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have the port cmd_valid, input, 1 bit: command request, sampled only in IDLE.
REQ-004 The block SHALL have the port opcode, input, 3 bits: 000 PUSH, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 POP, 111 NOP.
REQ-005 The block SHALL have the port operand, input, 8 bits: literal for PUSH, captured at accept.
REQ-006 The block SHALL have the port Push, output, 1 bit: single-cycle push strobe to the stack.
REQ-007 The block SHALL have the port Pop, output, 1 bit: single-cycle pop strobe to the stack.
REQ-008 The block SHALL have the port din, output, 8 bits: data to the stack, stable while Push=1.
REQ-009 The block SHALL have the port dout, input, 8 bits: stack pop data, valid the cycle after Pop.
REQ-010 The block SHALL have the ports full and empty, input, 1 bit each: stack flags, for cross-check only.
REQ-011 The block SHALL have the port busy, output, 1 bit: high from the accept cycle until DONE exits.
REQ-012 The block SHALL have the port result, output, 8 bits: last computed or popped value, held.
REQ-013 The block SHALL have the port result_valid, output, 1 bit: one-cycle pulse in DONE.
REQ-014 The block SHALL have the port error, output, 2 bits: 00 ok, 01 underflow, 10 overflow, 11 flag mismatch; held until the next accept.
REQ-015 The block SHALL have the port depth, output, 4 bits: internal occupancy count, 0..8.

Function
REQ-016 The FSM SHALL use the states IDLE, POP_B, CAP_B, POP_A, CAP_A, PUSH_R, DONE.
REQ-017 Accept SHALL occur in IDLE when cmd_valid=1; opcode and operand SHALL be latched, and busy SHALL rise the next cycle.
REQ-018 Push and Pop SHALL never both be 1 in the same cycle; each strobe SHALL be followed by at least one cycle with both low.
REQ-019 PUSH SHALL follow the path accept -> PUSH_R (Push=1, din=operand) -> DONE; depth SHALL increment by 1; result SHALL equal operand.
REQ-020 POP SHALL follow the path accept -> POP_B (Pop=1) -> CAP_B (B<=dout) -> DONE; depth SHALL decrement by 1; result SHALL equal B.
REQ-021 Binary ops SHALL follow the path POP_B -> CAP_B -> POP_A -> CAP_A -> PUSH_R (din=A op B) -> DONE; net depth SHALL change by -1.
REQ-022 The operand order SHALL be B = first popped (old top) and A = second popped; SUB SHALL compute A-B.
REQ-023 All arithmetic SHALL be 8-bit modulo 256, with no carry or borrow output.
REQ-024 NOP SHALL follow the path accept -> DONE, with no strobes and result unchanged.
REQ-025 Underflow SHALL be detected at accept: POP with depth=0, or binary op with depth<2; the FSM SHALL then go directly to DONE with error=01, no strobes, and result unchanged.
REQ-026 Overflow SHALL be detected at accept: PUSH with depth=8; the FSM SHALL then go directly to DONE with error=10 and no strobe.
REQ-027 Flag cross-check SHALL occur in DONE: if (depth==0)!=empty or (depth==8)!=full, error SHALL be set to 11; this check SHALL take priority over 00 only.
REQ-028 DONE SHALL last exactly one cycle with result_valid=1, then return to IDLE with busy=0.
REQ-029 cmd_valid SHALL be ignored while busy=1; a new command can be accepted on the IDLE cycle after DONE.
REQ-030 Latency from accept to result_valid SHALL be: PUSH 2 cycles, POP 3, binary op 6, NOP or error 1.

Reset
REQ-031 When reset_not=0, the block SHALL asynchronously set state=IDLE, depth=0, Push=0, Pop=0, din=0, result=0, result_valid=0, error=00, busy=0, and clear the latched opcode, operand, A and B.
REQ-032 Reset mid-operation SHALL abort the sequence immediately, and no further strobe SHALL be issued; the external stack is assumed reset by the same reset_not.
REQ-033 After reset_not rises, the first accept SHALL be possible on the next rising clk edge.

Verification
REQ-034 Scenario: PUSH 5, PUSH 3, SUB -> result=0x02, depth=1, error=00; then POP -> result=0x02, depth=0.
REQ-035 Scenario: PUSH 0xF0, PUSH 0x20, ADD -> result=0x10 (wrap), depth=1; PUSH 0x01, SUB on 0x10,0x01 -> result=0x0F.
REQ-036 Scenario: 8 PUSHes of 1..8, then a 9th PUSH -> error=10, no Push strobe, depth=8, full=1.
REQ-037 Scenario: after reset, ADD -> error=01 in 1 cycle, no Pop strobe; PUSH 7, ADD -> error=01, depth=1.
REQ-038 Scenario: assert reset_not=0 during CAP_A of XOR -> all outputs return to reset values at once, no Push follows, and depth=0 after release.
REQ-039 Scenario: hold cmd_valid=1 continuously through a binary op -> only one accept per IDLE; strobes stay single-cycle and never overlap.
